uart_rx_byte: RTL and testbench

UART_RX_BYTE -- requirements
Module: uart_rx_byte

---
 rtl/uart_rx_byte.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx_byte.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8-bit asynchronous serial receiver with mid-bit sampling.
// The line is oversampled at clk_50M. Each bit is sampled once near its centre
// and bits arrive LSB first, after one start bit and before one stop bit.
// Optional feature: define UART_RX_PARITY_EN for 8E1 framing, which adds an
// even-parity bit and the parity_err pulse. Without it, framing is 8N1 and
// parity_err is tied low.
// Output handshake: rx_complete, frame_err and parity_err are valid-only
// strobes. Each is high for exactly one clk_50M cycle, and at most one of them
// fires per frame. There is no ready or backpressure. rx_msg is valid from the
// rx_complete cycle until the next good frame.
// state_dbg exposes the FSM encoding so that checkers can bind to it.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_msg,
  output logic       rx_complete,
  output logic       frame_err,
  output logic       parity_err,
  output logic [2:0] state_dbg
);

  // Fixed encodings keep state_dbg stable whether or not parity is built in.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  // Timer end-counts.
  // HALF_END lands in the middle of the start bit.
  // BIT_END then steps one full bit at a time, which lands on each later bit's centre.
  localparam logic [15:0] HALF_END = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);

  state_t      state;
  logic [15:0] timer;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        rx_meta;
  logic        rx_s;
`ifdef UART_RX_PARITY_EN
  logic        par_mismatch;
`endif

  assign state_dbg = state;

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  // Two-flop synchronizer.
  // The flops reset to the idle-high line level, so releasing reset on an
  // idle line never looks like a start edge.
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Frame FSM: bit timing, shifting, and the registered result strobes.
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      rx_msg       <= '0;
      rx_complete  <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_mismatch <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      // Strobes default low, so each one lasts a single cycle.
      rx_complete <= 1'b0;
      frame_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          timer <= '0;
          if (!rx_s) begin
            state <= START;
          end
        end

        START: begin
          if (timer == HALF_END) begin
            timer <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              par_mismatch <= 1'b0;
`endif
            end else begin
              // The line went high again before mid start bit.
              // Treat it as a glitch and drop it without any pulse.
              state <= IDLE;
            end
          end else begin
            timer <= timer + 16'd1;
          end
        end

        DATA: begin
          if (timer == BIT_END) begin
            timer     <= '0;
            // Shift in from the top; after eight bits the first arrival sits in bit 0.
            shift_reg <= {rx_s, shift_reg[7:1]};
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            timer <= timer + 16'd1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (timer == BIT_END) begin
            timer        <= '0;
            // Even parity: the parity bit should equal the XOR of the data bits.
            par_mismatch <= rx_s ^ (^shift_reg);
            state        <= STOP;
          end else begin
            timer <= timer + 16'd1;
          end
        end
`endif

        STOP: begin
          if (timer == BIT_END) begin
            timer <= '0;
            if (rx_s) begin
              state <= IDLE;
`ifdef UART_RX_PARITY_EN
              if (par_mismatch) begin
                parity_err <= 1'b1;
              end else begin
                rx_msg      <= shift_reg;
                rx_complete <= 1'b1;
              end
`else
              rx_msg      <= shift_reg;
              rx_complete <= 1'b1;
`endif
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            timer <= timer + 16'd1;
          end
        end

        BREAK: begin
          // Wait out a held-low line.
          // frame_err was already pulsed once on entry, so nothing fires here.
          timer <= '0;
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed bench for uart_rx_byte at 434 clocks per bit.
// A table of single frames runs first.
// Hand-written sequences then cover the glitch, back-to-back,
// reset-mid-frame and parity cases.
module tb_uart_rx_byte;

  localparam int CPB = 434;
  localparam logic [2:0] IDLE_CODE = 3'd0;

  logic       clk_50M;
  logic       reset;
  logic       rx;
  logic [7:0] rx_msg;
  logic       rx_complete;
  logic       frame_err;
  logic       parity_err;
  logic [2:0] state_dbg;

  int checks   = 0;
  int failures = 0;
  int n_done   = 0;
  int n_ferr   = 0;
  int n_perr   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         hold_low;
    int         exp_done;
    int         exp_ferr;
    logic [7:0] exp_msg;
  } vec_t;

  vec_t vecs[4];

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk_50M    (clk_50M),
    .reset      (reset),
    .rx         (rx),
    .rx_msg     (rx_msg),
    .rx_complete(rx_complete),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .state_dbg  (state_dbg)
  );

  // Clock / reset block
  initial clk_50M = 1'b0;
  always #10 clk_50M = ~clk_50M;

  initial begin
    repeat (98000) @(posedge clk_50M);
    $display("FAIL watchdog cycle budget expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // Scoreboard: every rx_complete must match the head of exp_q.
  // At most one strobe may be high in any cycle.
  always @(negedge clk_50M) begin
    if (!reset) begin
      if (rx_complete) begin
        n_done++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_rx_complete got=%02h required=no_pulse", rx_msg);
        end else begin
          exp_b = exp_q.pop_front();
          if (rx_msg !== exp_b) begin
            failures++;
            $display("FAIL scoreboard_rx_msg got=%02h required=%02h", rx_msg, exp_b);
          end
        end
      end
      if (frame_err)  n_ferr++;
      if (parity_err) n_perr++;
      if (rx_complete || frame_err || parity_err) begin
        checks++;
        if ((int'(rx_complete) + int'(frame_err) + int'(parity_err)) > 1) begin
          failures++;
          $display("FAIL strobes_exclusive got=%b%b%b required=one_hot",
                   rx_complete, frame_err, parity_err);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  // Driver tasks
  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk_50M);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * CPB) @(posedge clk_50M);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^data);
`endif
    send_bit(stop_bit);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_bad_parity(input logic [7:0] data);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    send_bit(~(^data));
    send_bit(1'b1);
  endtask
`endif

  initial begin
    int d0;
    int f0;
    int p0;
    logic [7:0] msg_str[7];
    logic [7:0] a5;

    vecs[0] = '{data: 8'hFF, stop_bit: 1'b1, hold_low: 0,    exp_done: 1, exp_ferr: 0, exp_msg: 8'hFF};
    vecs[1] = '{data: 8'h23, stop_bit: 1'b1, hold_low: 0,    exp_done: 1, exp_ferr: 0, exp_msg: 8'h23};
    vecs[2] = '{data: 8'h55, stop_bit: 1'b0, hold_low: 5000, exp_done: 0, exp_ferr: 1, exp_msg: 8'h23};
    vecs[3] = '{data: 8'h42, stop_bit: 1'b1, hold_low: 0,    exp_done: 1, exp_ferr: 0, exp_msg: 8'h42};
    msg_str = '{8'h49, 8'h46, 8'h4D, 8'h2D, 8'h45, 8'h2D, 8'h23};

    // Reset state
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(posedge clk_50M);
    @(negedge clk_50M);
    check("reset_rx_msg", 32'(rx_msg), 32'h00);
    check("reset_rx_complete", 32'(rx_complete), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_parity_err", 32'(parity_err), 32'h0);
    check("reset_state", 32'(state_dbg), 32'(IDLE_CODE));
    reset = 1'b0;
    idle_bits(1);

    // Table-driven single frames
    for (int i = 0; i < 4; i++) begin
      d0 = n_done;
      f0 = n_ferr;
      if (vecs[i].exp_done == 1) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop_bit);
      if (vecs[i].hold_low > 0) begin
        rx = 1'b0;
        repeat (vecs[i].hold_low) @(posedge clk_50M);
      end
      idle_bits(1);
      @(negedge clk_50M);
      check($sformatf("vec%0d_done_pulses", i), 32'(n_done - d0), 32'(vecs[i].exp_done));
      check($sformatf("vec%0d_frame_err_pulses", i), 32'(n_ferr - f0), 32'(vecs[i].exp_ferr));
      check($sformatf("vec%0d_rx_msg", i), 32'(rx_msg), 32'(vecs[i].exp_msg));
      check($sformatf("vec%0d_state_idle", i), 32'(state_dbg), 32'(IDLE_CODE));
    end

    // Glitch: start edge that does not survive to mid-bit
    d0 = n_done;
    f0 = n_ferr;
    rx = 1'b0;
    repeat (100) @(posedge clk_50M);
    idle_bits(1);
    @(negedge clk_50M);
    check("glitch_no_done", 32'(n_done - d0), 32'd0);
    check("glitch_no_frame_err", 32'(n_ferr - f0), 32'd0);
    check("glitch_state_idle", 32'(state_dbg), 32'(IDLE_CODE));
    check("glitch_rx_msg_kept", 32'(rx_msg), 32'h42);
    exp_q.push_back(8'h50);
    send_frame(8'h50, 1'b1);
    idle_bits(1);
    @(negedge clk_50M);
    check("after_glitch_rx_msg", 32'(rx_msg), 32'h50);
    check("after_glitch_done", 32'(n_done - d0), 32'd1);

    // Back-to-back string, no idle time between frames
    d0 = n_done;
    for (int i = 0; i < 7; i++) exp_q.push_back(msg_str[i]);
    for (int i = 0; i < 7; i++) send_frame(msg_str[i], 1'b1);
    idle_bits(1);
    @(negedge clk_50M);
    check("b2b_done_count", 32'(n_done - d0), 32'd7);
    check("b2b_queue_drained", 32'(exp_q.size()), 32'd0);
    check("b2b_last_msg", 32'(rx_msg), 32'h23);

    // Reset in the middle of data bit 4 of 0xA5
    d0 = n_done;
    f0 = n_ferr;
    a5 = 8'hA5;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(a5[i]);
    rx = a5[4];
    repeat (CPB / 2) @(posedge clk_50M);
    #5 reset = 1'b1;
    #1;
    check("midreset_rx_msg", 32'(rx_msg), 32'h00);
    check("midreset_rx_complete", 32'(rx_complete), 32'h0);
    check("midreset_frame_err", 32'(frame_err), 32'h0);
    check("midreset_parity_err", 32'(parity_err), 32'h0);
    check("midreset_state", 32'(state_dbg), 32'(IDLE_CODE));
    repeat (CPB - CPB / 2) @(posedge clk_50M);
    for (int i = 5; i < 8; i++) send_bit(a5[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^a5);
`endif
    rx = 1'b1;
    repeat (CPB / 2) @(posedge clk_50M);
    @(negedge clk_50M);
    reset = 1'b0;
    idle_bits(2);
    @(negedge clk_50M);
    check("midreset_no_done", 32'(n_done - d0), 32'd0);
    check("midreset_no_frame_err", 32'(n_ferr - f0), 32'd0);
    check("midreset_state_idle", 32'(state_dbg), 32'(IDLE_CODE));
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    idle_bits(1);
    @(negedge clk_50M);
    check("after_reset_rx_msg", 32'(rx_msg), 32'h3C);
    check("after_reset_done", 32'(n_done - d0), 32'd1);

`ifdef UART_RX_PARITY_EN
    // Parity: 0x41 has two ones, so the even parity bit is 0
    d0 = n_done;
    p0 = n_perr;
    send_bad_parity(8'h41);
    idle_bits(1);
    @(negedge clk_50M);
    check("bad_parity_pulses", 32'(n_perr - p0), 32'd1);
    check("bad_parity_no_done", 32'(n_done - d0), 32'd0);
    check("bad_parity_rx_msg_kept", 32'(rx_msg), 32'h3C);
    exp_q.push_back(8'h41);
    send_frame(8'h41, 1'b1);
    idle_bits(1);
    @(negedge clk_50M);
    check("good_parity_rx_msg", 32'(rx_msg), 32'h41);
    check("good_parity_done", 32'(n_done - d0), 32'd1);
    check("parity_err_total", 32'(n_perr), 32'd1);
`else
    p0 = n_perr;
    check("parity_err_never", 32'(p0), 32'd0);
`endif

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
